// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side stage for a lookahead synchronous FIFO. Waits until the FIFO
// holds at least BURST_LEN words, then drains exactly BURST_LEN words onto a
// registered valid/ready stream, marking the final beat with m_last.
//
// Optional feature (macro FIFO_BURST_RD_TIMEOUT_EN): when fewer than
// BURST_LEN words have sat in the FIFO for TIMEOUT cycles, the words present
// are flushed as a short burst.
//
// Handshake: a beat transfers on a rising edge where m_valid & m_ready are
// both high. While m_valid is high and m_ready is low, m_data/m_last/m_valid
// hold and no FIFO word is read.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sclr         synchronous clear (issued together with the FIFO's sclr)
//   fifo_data    FIFO head word (valid while !fifo_empty)
//   fifo_empty   FIFO empty flag
//   fifo_uw      FIFO used-word count, ADDR_WIDTH+1 bits
//   fifo_rd_en   FIFO read enable (combinational)
//   m_valid      output beat valid (registered)
//   m_ready      downstream accepts the beat
//   m_data       output beat data (registered)
//   m_last       last beat of the burst (registered)
//   m_len        length of the current burst, held from first to last beat
//   busy         high while a burst is being issued (BURST or DRAIN)
//   state_dbg    current FSM state (0=IDLE, 1=BURST, 2=DRAIN)
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_uw,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [ADDR_WIDTH:0]   m_len,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] BL = LW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_WIDTH) || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_burst_reader: BURST_LEN or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   remaining_q;
  logic            start_full;
  logic            start_part;
  logic            accept;

`ifdef FIFO_BURST_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;
`endif

  assign accept    = m_valid & m_ready;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // Next-state and read-enable logic.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    start_full = 1'b0;
    start_part = 1'b0;
    case (state_q)
      IDLE: begin
        // A full burst wins over a timeout flush in the same cycle.
        if (fifo_uw >= BL) begin
          state_d    = BURST;
          start_full = 1'b1;
        end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        else if (timer_q == TO_LAST && !fifo_empty) begin
          state_d    = BURST;
          start_part = 1'b1;
        end
`endif
      end
      BURST: begin
        // The empty guard is redundant with the start check but keeps the
        // FIFO safe from underflow regardless of upstream behaviour.
        fifo_rd_en = (remaining_q != '0) & ~fifo_empty & (~m_valid | m_ready);
        if (fifo_rd_en && remaining_q == LW'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (sclr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register and burst counter. sclr aborts any burst in flight
  // without issuing m_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_len       <= '0;
      remaining_q <= '0;
    end else if (sclr) begin
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_len       <= '0;
      remaining_q <= '0;
    end else begin
      if (start_full) begin
        remaining_q <= BL;
        m_len       <= BL;
      end else if (start_part) begin
        remaining_q <= fifo_uw;
        m_len       <= fifo_uw;
      end

      if (fifo_rd_en) begin
        m_data      <= fifo_data;
        m_valid     <= 1'b1;
        m_last      <= (remaining_q == LW'(1));
        remaining_q <= remaining_q - LW'(1);
      end else if (accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

`ifdef FIFO_BURST_RD_TIMEOUT_EN
  // Counts cycles a partial word count has been waiting in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (sclr || state_q != IDLE || state_d != IDLE || fifo_empty) begin
      timer_q <= '0;
    end else if (fifo_uw < BL) begin
      timer_q <= timer_q + TW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed bench for fifo_burst_reader. A behavioural lookahead FIFO feeds
// the DUT; a monitor records every accepted beat (data, last, len, cycle)
// and counts backpressure hold violations and FIFO underflows. Each test
// task drives its scenario and compares the recorded beats against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BL = 16;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclr = 1'b0;
  logic m_ready = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic [AW:0]   fifo_uw = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [AW:0]   m_len;
  logic          busy;
  logic [1:0]    state_dbg;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_uw(fifo_uw),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_len(m_len), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] wr_q[$];
  logic          rd_snap = 1'b0;
  int            underflow_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      wr_q.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
      fifo_uw    <= '0;
    end else begin
      if (sclr) begin
        fq.delete();
        wr_q.delete();
      end else begin
        if (rd_snap) begin
          if (fq.size() == 0) underflow_cnt++;
          else void'(fq.pop_front());
        end
        if (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
      end
      fifo_data  <= (fq.size() > 0) ? fq[0] : '0;
      fifo_empty <= (fq.size() == 0);
      fifo_uw    <= (AW+1)'(fq.size());
    end
  end

  // ---------------- monitor ----------------
  int            cyc = 0;
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic [AW:0]   got_len[$];
  int            got_c[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  int            hold_err = 0;

  always @(posedge clk) cyc++;

  // Samples 1 time unit before each rising edge, after the bench has
  // settled its inputs on the falling edge.
  always begin
    @(negedge clk);
    #4;
    rd_snap = fifo_rd_en;
    if (rst_n && !sclr) begin
      if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) hold_err++;
      if (m_valid && !m_ready && fifo_rd_en) hold_err++;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_len.push_back(m_len);
        got_c.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- counters / driver tasks ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) wr_q.push_back(base + DW'(i));
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    got_len.delete();
    got_c.delete();
    hold_err = 0;
    underflow_cnt = 0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && got_d.size() < n; c++) @(negedge clk);
  endtask

  task automatic pulse_sclr();
    @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({m_valid, m_last, busy, fifo_rd_en, state_dbg} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000", {m_valid, m_last, busy, fifo_rd_en, state_dbg});
    end
    n_cmp++;
    if (m_data !== '0) begin
      n_err++;
      $display("FAIL reset_m_data: got %0h want 0", m_data);
    end
    n_cmp++;
    if (m_len !== '0) begin
      n_err++;
      $display("FAIL reset_m_len: got %0d want 0", m_len);
    end
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int n;
    clear_mon();
    write_words(32'h100, 16);
    wait_beats(16, 200);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 16) begin
      n_err++;
      $display("FAIL single_count: got %0d want 16", got_d.size());
    end
    n = (got_d.size() < 16) ? got_d.size() : 16;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h100 + DW'(i) || got_l[i] !== (i == 15) || got_len[i] !== 9'd16) begin
        n_err++;
        $display("FAIL single_beat%0d: got d=%0h l=%0b len=%0d want d=%0h l=%0b len=16",
                 i, got_d[i], got_l[i], got_len[i], 32'h100 + i, (i == 15));
      end
      if (i > 0) begin
        n_cmp++;
        if (got_c[i] != got_c[0] + i) begin
          n_err++;
          $display("FAIL single_gap%0d: got cycle %0d want %0d", i, got_c[i], got_c[0] + i);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_two_bursts();
    int n;
    clear_mon();
    write_words(32'h200, 40);
    wait_beats(32, 300);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 32) begin
      n_err++;
      $display("FAIL two_count: got %0d want 32", got_d.size());
    end
    n = (got_d.size() < 32) ? got_d.size() : 32;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h200 + DW'(i) || got_l[i] !== ((i % 16) == 15) || got_len[i] !== 9'd16) begin
        n_err++;
        $display("FAIL two_beat%0d: got d=%0h l=%0b len=%0d want d=%0h l=%0b len=16",
                 i, got_d[i], got_l[i], got_len[i], 32'h200 + i, ((i % 16) == 15));
      end
    end
    n_cmp++;
    if (fifo_uw !== 9'd8) begin
      n_err++;
      $display("FAIL two_leftover_uw: got %0d want 8", fifo_uw);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL two_busy_after: got %b want 0", busy);
    end
    pulse_sclr();
  endtask

  task automatic test_backpressure();
    int n;
    int c;
    clear_mon();
    write_words(32'h300, 16);
    c = 0;
    while (c < 400 && got_d.size() < 16) begin
      @(negedge clk);
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      c++;
    end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 16) begin
      n_err++;
      $display("FAIL bp_count: got %0d want 16", got_d.size());
    end
    n = (got_d.size() < 16) ? got_d.size() : 16;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h300 + DW'(i) || got_l[i] !== (i == 15)) begin
        n_err++;
        $display("FAIL bp_beat%0d: got d=%0h l=%0b want d=%0h l=%0b",
                 i, got_d[i], got_l[i], 32'h300 + i, (i == 15));
      end
    end
    n_cmp++;
    if (hold_err != 0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d hold violations want 0", hold_err);
    end
    n_cmp++;
    if (underflow_cnt != 0) begin
      n_err++;
      $display("FAIL bp_underflow: got %0d want 0", underflow_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_mon();
    write_words(32'h380, 5);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 0) begin
      n_err++;
      $display("FAIL to_early: got %0d beats want 0", got_d.size());
    end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
    wait_beats(5, 150);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 5) begin
      n_err++;
      $display("FAIL to_count: got %0d want 5", got_d.size());
    end
    n = (got_d.size() < 5) ? got_d.size() : 5;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h380 + DW'(i) || got_l[i] !== (i == 4) || got_len[i] !== 9'd5) begin
        n_err++;
        $display("FAIL to_beat%0d: got d=%0h l=%0b len=%0d want d=%0h l=%0b len=5",
                 i, got_d[i], got_l[i], got_len[i], 32'h380 + i, (i == 4));
      end
    end
`else
    n = 0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (got_d.size() != n) begin
      n_err++;
      $display("FAIL to_none: got %0d beats want 0", got_d.size());
    end
    n_cmp++;
    if (fifo_uw !== 9'd5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_idle: got uw=%0d busy=%b want uw=5 busy=0", fifo_uw, busy);
    end
`endif
    pulse_sclr();
  endtask

  task automatic test_sclr_mid();
    int n;
    int lasts;
    clear_mon();
    write_words(32'h400, 16);
    wait_beats(6, 200);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    n_cmp++;
    if ({m_valid, busy, state_dbg} !== 4'b0 || m_len !== '0) begin
      n_err++;
      $display("FAIL sclr_state: got valid=%b busy=%b state=%0d len=%0d want all 0",
               m_valid, busy, state_dbg, m_len);
    end
    lasts = 0;
    foreach (got_l[i]) if (got_l[i]) lasts++;
    n_cmp++;
    if (lasts != 0 || got_d.size() >= 16) begin
      n_err++;
      $display("FAIL sclr_trunc: got %0d lasts %0d beats want 0 lasts <16 beats", lasts, got_d.size());
    end
    repeat (2) @(negedge clk);
    clear_mon();
    write_words(32'h480, 16);
    wait_beats(16, 200);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 16) begin
      n_err++;
      $display("FAIL sclr_resume_count: got %0d want 16", got_d.size());
    end
    n = (got_d.size() < 16) ? got_d.size() : 16;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h480 + DW'(i) || got_l[i] !== (i == 15) || got_len[i] !== 9'd16) begin
        n_err++;
        $display("FAIL sclr_resume_beat%0d: got d=%0h l=%0b len=%0d want d=%0h l=%0b len=16",
                 i, got_d[i], got_l[i], got_len[i], 32'h480 + i, (i == 15));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    clear_mon();
    write_words(32'h500, 16);
    wait_beats(4, 200);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_last, busy, fifo_rd_en, state_dbg} !== 6'b0) begin
      n_err++;
      $display("FAIL arst_ctrl: got %b want 000000", {m_valid, m_last, busy, fifo_rd_en, state_dbg});
    end
    n_cmp++;
    if (m_data !== '0 || m_len !== '0) begin
      n_err++;
      $display("FAIL arst_data: got d=%0h len=%0d want 0 0", m_data, m_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    write_words(32'h600, 16);
    wait_beats(16, 200);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_d.size() != 16) begin
      n_err++;
      $display("FAIL arst_resume_count: got %0d want 16", got_d.size());
    end
    n = (got_d.size() < 16) ? got_d.size() : 16;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_d[i] !== 32'h600 + DW'(i) || got_l[i] !== (i == 15) || got_len[i] !== 9'd16) begin
        n_err++;
        $display("FAIL arst_resume_beat%0d: got d=%0h l=%0b len=%0d want d=%0h l=%0b len=16",
                 i, got_d[i], got_l[i], got_len[i], 32'h600 + i, (i == 15));
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_backpressure();
    test_timeout();
    test_sclr_mid();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
